uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   UART serial receiver: 8N1-style frame, LSB first, 16x oversampled. Consumes
//   the 1-cycle o_tick strobe of the baud-rate generator (16 ticks per bit) and
//   deserialises i_rx into parallel bytes. Sits between the pad and the RX FIFO
//   or the parallel interface; pairs with the UART transmitter on the far end.
// PARAMETERS
//   DBIT     8   data bits per frame (5..8)
//   SB_TICK  16  ticks spent in the stop state (16 = 1 stop bit, 32 = 2)
//   OVS      16  ticks per bit; must match the baud-rate generator setting
// PORTS
//   i_clk        in   1     system clock
//   i_reset      in   1     asynchronous, active-high reset
//   i_tick       in   1     oversampling strobe, 1 clk wide, from baud generator
//   i_rx         in   1     serial line, idle high, asynchronous to i_clk
//   o_data       out  DBIT  last received byte, held until the next frame ends
//   o_rx_done    out  1     1-clk pulse: o_data valid (good or bad frame)
//   o_frame_err  out  1     qualifies o_rx_done: stop bit sampled low
// BEHAVIOUR
//   - Reset: one clock and one reset; i_reset is asynchronous and active-high.
//     All flops clear immediately. state=IDLE, o_data=0, o_rx_done=0,
//     o_frame_err=0. Synchroniser flops preset to 1 (line idle).
//   - i_rx passes through a 2-flop synchroniser (rx_s). Latency to the FSM is
//     2 clk. Only rx_s is used internally.
//   - The FSM advances only on cycles with i_tick=1, except IDLE->START, which
//     happens on any clk where rx_s=0. s_cnt is a 4-bit tick counter; n_cnt
//     counts data bits (width $clog2(DBIT)).
//   - IDLE: s_cnt=0. If rx_s==0, go to START.
//   - START: on tick with s_cnt==OVS/2-1 (7), this is mid start bit:
//       rx_s==0 -> s_cnt=0, n_cnt=0, go to DATA;
//       rx_s==1 -> glitch, go to IDLE with no output.
//     Otherwise s_cnt++.
//   - DATA: on tick with s_cnt==OVS-1, this is mid bit: shift rx_s into the MSB
//     of shreg (shift right; LSB arrives first), s_cnt=0. If n_cnt==DBIT-1, go
//     to STOP; else n_cnt++. Otherwise s_cnt++.
//   - STOP: on tick with s_cnt==SB_TICK-1, this is mid stop bit (1 stop bit),
//     then:
//       o_data<=shreg, o_frame_err<=~rx_s, o_rx_done<=1 for exactly 1 clk,
//       go to IDLE.
//     Otherwise s_cnt++.
//   - o_rx_done is registered: it is high on the clk after the final stop tick.
//     o_frame_err and o_data hold until the next o_rx_done.
//   - A frame error does not block reception. Line still low in IDLE (break)
//     -> a new START is entered; a glitch is rejected there.
//   - i_tick may be tied high in simulation; the FSM then runs at 1 sample/clk.
//   - Reset mid-frame: abort with no o_rx_done; the first frame after reset
//     needs a falling edge from an idle-high line.
//   - Back-to-back frames: the next start edge can be accepted on the clk after
//     STOP exits. No bytes are lost at full line rate.
// STRUCTURE
//   - uart_defs.vh (shared with the TX side): state encodings
//     ST_IDLE/ST_START/ST_DATA/ST_STOP (2 bits) and the default OVS=16.
//   - Sub-module sync_2ff (generic 2-flop synchroniser, with a reset-value
//     parameter). It is reused for other asynchronous inputs.
//   - The FSM, counters and shift register are inline in uart_rx.
// TESTING
//   Bench: baud generator with NCYCLES_PER_TICK=4, DBIT=8, SB_TICK=16.
//   Bit period is 64 clk.
//   1. Send 0x55 (start,10101010 LSB first,stop) -> one o_rx_done pulse,
//      o_data=0x55, o_frame_err=0.
//   2. Send 0xA3 then 0x0F back-to-back, no idle gap -> two pulses ~640 clk
//      apart, with o_data 0xA3 then 0x0F.
//   3. Low glitch of 16 clk (< half bit) on an idle line -> no o_rx_done;
//      FSM back in IDLE; a following 0x3C is received correctly.
//   4. Send 0x81 with the stop bit driven low -> o_rx_done=1, o_frame_err=1,
//      o_data=0x81. The next good frame clears o_frame_err.
//   5. Assert i_reset during data bit 4 of a frame -> outputs 0 immediately,
//      no pulse. A clean 0xC6 after release -> o_data=0xC6.
//   6. Tick jitter: bit period +/-3% vs the sampling clock over 0x00 and 0xFF
//      frames -> correct data, no frame error.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver/transmitter FSM state encodings and default oversampling.
// Pure declarations; no logic, no latency, no flow control.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_e;

   localparam int OVS_DEFAULT = 16;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Generic 2-flop synchroniser for asynchronous inputs, with configurable reset value.
// Latency 2 clk; no backpressure (free-running sampler).
module sync_2ff #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = i_d;
      sync_d = meta_q;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver (start, DBIT data LSB first, stop); outputs byte + done/frame-error.
// o_rx_done one clk after the mid-stop tick (plus 2 clk input sync); no backpressure, consumer must take each byte.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int OVS     = OVS_DEFAULT
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_tick,
   input  logic            i_rx,
   output logic [DBIT-1:0] o_data,
   output logic            o_rx_done,
   output logic            o_frame_err
);

   localparam int CW = $clog2((SB_TICK > OVS) ? SB_TICK : OVS);
   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [CW-1:0] MID_START = CW'(OVS / 2 - 1);
   localparam logic [CW-1:0] MID_BIT   = CW'(OVS - 1);
   localparam logic [CW-1:0] MID_STOP  = CW'(SB_TICK - 1);
   localparam logic [NW-1:0] LAST_BIT  = NW'(DBIT - 1);

   logic            rx_s;
   rx_state_e       state_q, state_d;
   logic [CW-1:0]   s_cnt_q, s_cnt_d;
   logic [NW-1:0]   n_cnt_q, n_cnt_d;
   logic [DBIT-1:0] shreg_q, shreg_d;
   logic [DBIT-1:0] data_q, data_d;
   logic            rx_done_q, rx_done_d;
   logic            frame_err_q, frame_err_d;

   // Line idles high, so the synchroniser resets to 1 to avoid a false start.
   sync_2ff #(
      .WIDTH   (1),
      .RST_VAL (1'b1)
   ) u_sync_rx (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (i_rx),
      .o_q     (rx_s)
   );

   always_comb begin
      state_d     = state_q;
      s_cnt_d     = s_cnt_q;
      n_cnt_d     = n_cnt_q;
      shreg_d     = shreg_q;
      data_d      = data_q;
      rx_done_d   = 1'b0;
      frame_err_d = frame_err_q;

      case (state_q)
         ST_IDLE: begin
            s_cnt_d = '0;
            if (!rx_s) state_d = ST_START;
         end
         ST_START: begin
            if (i_tick) begin
               if (s_cnt_q == MID_START) begin
                  if (!rx_s) begin
                     s_cnt_d = '0;
                     n_cnt_d = '0;
                     state_d = ST_DATA;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + CW'(1);
               end
            end
         end
         ST_DATA: begin
            if (i_tick) begin
               if (s_cnt_q == MID_BIT) begin
                  shreg_d = {rx_s, shreg_q[DBIT-1:1]};
                  s_cnt_d = '0;
                  if (n_cnt_q == LAST_BIT) state_d = ST_STOP;
                  else                     n_cnt_d = n_cnt_q + NW'(1);
               end else begin
                  s_cnt_d = s_cnt_q + CW'(1);
               end
            end
         end
         ST_STOP: begin
            if (i_tick) begin
               if (s_cnt_q == MID_STOP) begin
                  data_d      = shreg_q;
                  frame_err_d = ~rx_s;
                  rx_done_d   = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  s_cnt_d = s_cnt_q + CW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         s_cnt_q     <= '0;
         n_cnt_q     <= '0;
         shreg_q     <= '0;
         data_q      <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_cnt_q     <= s_cnt_d;
         n_cnt_q     <= n_cnt_d;
         shreg_q     <= shreg_d;
         data_q      <= data_d;
         rx_done_q   <= rx_done_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign o_data      = data_q;
   assign o_rx_done   = rx_done_q;
   assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every 4 clk (64 clk per bit), frames driven LSB first.
module tb_uart_rx;
   import uart_rx_pkg::*;

   logic       clk;
   logic       i_reset;
   logic       i_tick;
   logic       i_rx;
   logic [7:0] o_data;
   logic       o_rx_done;
   logic       o_frame_err;

   int checks = 0;
   int errors = 0;

   int          done_cnt = 0;
   int          cyc      = 0;
   logic [7:0]  rx_log  [0:63];
   logic        err_log [0:63];
   int          time_log[0:63];

   uart_rx #(
      .DBIT    (8),
      .SB_TICK (16),
      .OVS     (16)
   ) dut (
      .i_clk       (clk),
      .i_reset     (i_reset),
      .i_tick      (i_tick),
      .i_rx        (i_rx),
      .o_data      (o_data),
      .o_rx_done   (o_rx_done),
      .o_frame_err (o_frame_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Baud generator: one-clk tick every 4 clk, driven on the falling edge.
   initial begin
      int tcnt;
      tcnt   = 0;
      i_tick = 1'b0;
      forever begin
         @(negedge clk);
         tcnt   = (tcnt == 3) ? 0 : tcnt + 1;
         i_tick = (tcnt == 3);
      end
   end

   // Pulse logger, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         cyc = cyc + 1;
         if (o_rx_done && done_cnt < 64) begin
            rx_log[done_cnt]   = o_data;
            err_log[done_cnt]  = o_frame_err;
            time_log[done_cnt] = cyc;
            done_cnt           = done_cnt + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      i_rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_val,
                             input int bit_clks, input int stop_clks);
      i_rx = 1'b0;
      repeat (bit_clks) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         i_rx = b[i];
         repeat (bit_clks) @(negedge clk);
      end
      i_rx = stop_val;
      repeat (stop_clks) @(negedge clk);
      i_rx = 1'b1;
   endtask

   initial begin
      int base;
      logic [7:0] part;

      i_reset = 1'b1;
      i_rx    = 1'b1;
      #1;
      check("rst_data", 32'(o_data), 32'h00);
      check("rst_done", 32'(o_rx_done), 32'h0);
      check("rst_ferr", 32'(o_frame_err), 32'h0);
      check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      repeat (5) @(negedge clk);
      i_reset = 1'b0;
      idle(20);

      // 1. single good frame
      base = done_cnt;
      send_frame(8'h55, 1'b1, 64, 64);
      idle(64);
      check("t1_count", 32'(done_cnt - base), 32'd1);
      check("t1_data", 32'(rx_log[base]), 32'h55);
      check("t1_ferr", 32'(err_log[base]), 32'h0);

      // 2. back-to-back frames with no idle gap
      base = done_cnt;
      send_frame(8'hA3, 1'b1, 64, 64);
      send_frame(8'h0F, 1'b1, 64, 64);
      idle(64);
      check("t2_count", 32'(done_cnt - base), 32'd2);
      check("t2_data0", 32'(rx_log[base]), 32'hA3);
      check("t2_data1", 32'(rx_log[base + 1]), 32'h0F);
      check("t2_spacing", 32'(time_log[base + 1] - time_log[base]), 32'd640);

      // 3. short low glitch is rejected, then a good frame
      base = done_cnt;
      i_rx = 1'b0;
      repeat (16) @(negedge clk);
      idle(96);
      check("t3_nopulse", 32'(done_cnt - base), 32'd0);
      check("t3_state", 32'(dut.state_q), 32'(ST_IDLE));
      send_frame(8'h3C, 1'b1, 64, 64);
      idle(64);
      check("t3_count", 32'(done_cnt - base), 32'd1);
      check("t3_data", 32'(rx_log[base]), 32'h3C);
      check("t3_ferr", 32'(err_log[base]), 32'h0);

      // 4. stop bit low -> frame error, cleared by the next good frame
      base = done_cnt;
      send_frame(8'h81, 1'b0, 64, 40);
      idle(128);
      check("t4_count", 32'(done_cnt - base), 32'd1);
      check("t4_data", 32'(rx_log[base]), 32'h81);
      check("t4_ferr", 32'(err_log[base]), 32'h1);
      check("t4_ferr_hold", 32'(o_frame_err), 32'h1);
      send_frame(8'h7E, 1'b1, 64, 64);
      idle(64);
      check("t4_count2", 32'(done_cnt - base), 32'd2);
      check("t4_data2", 32'(rx_log[base + 1]), 32'h7E);
      check("t4_ferr_clr", 32'(o_frame_err), 32'h0);

      // 5. reset asserted during data bit 4
      base = done_cnt;
      part = 8'hA5;
      i_rx = 1'b0;
      repeat (64) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         i_rx = part[i];
         repeat (64) @(negedge clk);
      end
      i_rx = part[4];
      repeat (32) @(negedge clk);
      i_reset = 1'b1;
      #1;
      check("t5_rst_data", 32'(o_data), 32'h00);
      check("t5_rst_done", 32'(o_rx_done), 32'h0);
      check("t5_rst_ferr", 32'(o_frame_err), 32'h0);
      check("t5_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      @(negedge clk);
      i_rx = 1'b1;
      repeat (4) @(negedge clk);
      i_reset = 1'b0;
      idle(400);
      check("t5_nopulse", 32'(done_cnt - base), 32'd0);
      send_frame(8'hC6, 1'b1, 64, 64);
      idle(64);
      check("t5_count", 32'(done_cnt - base), 32'd1);
      check("t5_data", 32'(rx_log[base]), 32'hC6);
      check("t5_ferr", 32'(err_log[base]), 32'h0);

      // 6. bit period ~+/-3% off nominal (62 and 66 clk)
      base = done_cnt;
      send_frame(8'h00, 1'b1, 62, 62);
      idle(64);
      send_frame(8'h00, 1'b1, 66, 66);
      idle(64);
      send_frame(8'hFF, 1'b1, 62, 62);
      idle(64);
      send_frame(8'hFF, 1'b1, 66, 66);
      idle(64);
      check("t6_count", 32'(done_cnt - base), 32'd4);
      check("t6_fast00", 32'(rx_log[base]), 32'h00);
      check("t6_slow00", 32'(rx_log[base + 1]), 32'h00);
      check("t6_fastFF", 32'(rx_log[base + 2]), 32'hFF);
      check("t6_slowFF", 32'(rx_log[base + 3]), 32'hFF);
      check("t6_ferr", 32'({err_log[base], err_log[base + 1], err_log[base + 2], err_log[base + 3]}), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
